drp_adc_responder: RTL and testbench

Synthesizable DRP responder that emulates the XADC dynamic-reconfiguration-port slave. It is the responder end of the DRP read loop driven by the LED-brightness top level.
- Runs a free-running conversion sequencer over four aux channels and raises eoc_out after each conversion.
- Answers den/dwe/daddr/di transactions with do/drdy after a fixed latency.
- Serves as a drop-in simulation/bring-up substitute for the hard XADC when driving the existing DRP initiator.

---
 rtl/drp_adc_pkg.sv | 33 +++
 rtl/adc_conv_sequencer.sv | 66 ++++++
 rtl/drp_adc_responder.sv | 188 ++++++++++++++++++
 tb/tb_drp_adc_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_adc_pkg.sv
// Shared constants for the DRP ADC responder: register addresses, the DRP
// handshake state encoding, and the conversion sequence order.
package drp_adc_pkg;

    localparam logic [6:0] ADDR_AUX6  = 7'h16;
    localparam logic [6:0] ADDR_AUX7  = 7'h17;
    localparam logic [6:0] ADDR_AUX14 = 7'h1E;
    localparam logic [6:0] ADDR_AUX15 = 7'h1F;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;

    localparam int CFG1_PAUSE_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } drp_state_e;

    // Map a sequence slot (0..3) to the sample register address it converts.
    function automatic logic [6:0] seq_addr(input logic [1:0] idx);
        logic [6:0] addr;
        case (idx)
            2'd0:    addr = ADDR_AUX6;
            2'd1:    addr = ADDR_AUX7;
            2'd2:    addr = ADDR_AUX14;
            2'd3:    addr = ADDR_AUX15;
            default: addr = ADDR_AUX6;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/adc_conv_sequencer.sv
// Free-running conversion sequencer: steps through the four aux channels,
// one slot of CONV_CYCLES clocks each, and pulses eoc at the end of a slot.
// load_en_o is combinational so the sample register loads on the same edge
// that raises eoc_o and updates channel_o.
module adc_conv_sequencer
    import drp_adc_pkg::*;
#(
    parameter int CONV_CYCLES = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_i,
    output logic [3:0] load_en_o,
    output logic       eoc_o,
    output logic [6:0] channel_o
);

    localparam int TIMER_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CONV_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         idx_q, idx_d;
    logic               eoc_q, eoc_d;
    logic [6:0]         chan_q, chan_d;

    // Next-state for timer/index and the end-of-slot load strobe.
    always_comb begin
        timer_d   = timer_q;
        idx_d     = idx_q;
        eoc_d     = 1'b0;
        chan_d    = chan_q;
        load_en_o = 4'b0000;
        if (pause_i) begin
            timer_d = timer_q;
        end else if (timer_q == TIMER_LAST) begin
            timer_d   = TIMER_ZERO;
            idx_d     = idx_q + 2'd1;
            eoc_d     = 1'b1;
            chan_d    = seq_addr(idx_q);
            load_en_o = 4'b0001 << idx_q;
        end else begin
            timer_d = timer_q + TIMER_ONE;
        end
    end

    // Sequencer state and registered eoc/channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= TIMER_ZERO;
            idx_q   <= 2'd0;
            eoc_q   <= 1'b0;
            chan_q  <= 7'h00;
        end else begin
            timer_q <= timer_d;
            idx_q   <= idx_d;
            eoc_q   <= eoc_d;
            chan_q  <= chan_d;
        end
    end

    assign eoc_o     = eoc_q;
    assign channel_o = chan_q;

endmodule

// File: rtl/drp_adc_responder.sv
// XADC-style DRP slave for bring-up: a conversion sequencer fills four
// left-justified sample registers, and a small handshake FSM answers DRP
// reads/writes with a fixed den-to-drdy latency of READ_LATENCY clocks.
module drp_adc_responder
    import drp_adc_pkg::*;
#(
    parameter int CONV_CYCLES  = 26,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    output logic [6:0]  channel_out,
    input  logic [11:0] ain0_in,
    input  logic [11:0] ain1_in,
    input  logic [11:0] ain2_in,
    input  logic [11:0] ain3_in,
    output logic        drp_err_out
);

    // Counter loads READ_LATENCY-2: one clock is spent in IDLE accepting,
    // one in RESP presenting drdy, the rest counting down in BUSY.
    localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 2);
    localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    drp_state_e         state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [6:0]         addr_q, addr_d;
    logic               we_q, we_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        do_q, do_d;
    logic               drdy_q, drdy_d;
    logic               err_q, err_d;
    logic [15:0]        cfg0_q, cfg0_d;
    logic [15:0]        cfg1_q, cfg1_d;
    logic [3:0][11:0]   sample_q;
    logic [3:0][11:0]   ain_s;
    logic [3:0]         load_en_s;
    logic [15:0]        rd_data_s;
    logic               pause_s;

    assign ain_s   = {ain3_in, ain2_in, ain1_in, ain0_in};
    assign pause_s = cfg1_q[CFG1_PAUSE_BIT];

    adc_conv_sequencer #(
        .CONV_CYCLES (CONV_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause_i   (pause_s),
        .load_en_o (load_en_s),
        .eoc_o     (eoc_out),
        .channel_o (channel_out)
    );

    // Sample registers load on the sequencer's end-of-slot strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= {4{12'h000}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_en_s[k]) begin
                    sample_q[k] <= ain_s[k];
                end
            end
        end
    end

    // Read mux over the register map; unmapped addresses read zero.
    always_comb begin
        rd_data_s = 16'h0000;
        case (addr_q)
            ADDR_AUX6:  rd_data_s = {sample_q[0], 4'h0};
            ADDR_AUX7:  rd_data_s = {sample_q[1], 4'h0};
            ADDR_AUX14: rd_data_s = {sample_q[2], 4'h0};
            ADDR_AUX15: rd_data_s = {sample_q[3], 4'h0};
            ADDR_CFG0:  rd_data_s = cfg0_q;
            ADDR_CFG1:  rd_data_s = cfg1_q;
            default:    rd_data_s = 16'h0000;
        endcase
    end

    // DRP handshake next-state, response data, config writes and error flag.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        do_d    = do_q;
        drdy_d  = 1'b0;
        err_d   = err_q;
        cfg0_d  = cfg0_q;
        cfg1_d  = cfg1_q;
        case (state_q)
            ST_IDLE: begin
                if (den_in) begin
                    addr_d  = daddr_in;
                    we_d    = dwe_in;
                    wdata_d = di_in;
                    lat_d   = LAT_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (den_in) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (lat_q == LAT_ZERO) begin
                    if (we_q) begin
                        do_d = 16'h0000;
                        case (addr_q)
                            ADDR_CFG0: cfg0_d = wdata_q;
                            ADDR_CFG1: cfg1_d = wdata_q;
                            default: begin
                                cfg0_d = cfg0_q;
                                cfg1_d = cfg1_q;
                            end
                        endcase
                    end else begin
                        // Uses current register values: a sample loaded on
                        // this same edge is not visible to this read.
                        do_d = rd_data_s;
                    end
                    drdy_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            ST_RESP: begin
                if (den_in) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DRP state and registered outputs; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lat_q   <= LAT_ZERO;
            addr_q  <= 7'h00;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
            do_q    <= 16'h0000;
            drdy_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg0_q  <= 16'h0000;
            cfg1_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            do_q    <= do_d;
            drdy_q  <= drdy_d;
            err_q   <= err_d;
            cfg0_q  <= cfg0_d;
            cfg1_q  <= cfg1_d;
        end
    end

    assign do_out      = do_q;
    assign drdy_out    = drdy_q;
    assign drp_err_out = err_q;

endmodule

// File: tb/tb_drp_adc_responder.sv
// Bench for drp_adc_responder: directed scenarios plus randomized DRP traffic,
// checked every cycle against a transaction-level reference model.
module tb_drp_adc_responder;

    localparam int CONV = 26;
    localparam int RLAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        den_in = 1'b0;
    logic        dwe_in = 1'b0;
    logic [6:0]  daddr_in = 7'h00;
    logic [15:0] di_in = 16'h0000;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        eoc_out;
    logic [6:0]  channel_out;
    logic [11:0] ain0 = 12'h000, ain1 = 12'h000, ain2 = 12'h000, ain3 = 12'h000;
    logic        drp_err_out;

    int n_checks = 0;
    int n_fail   = 0;

    drp_adc_responder #(.CONV_CYCLES(CONV), .READ_LATENCY(RLAT)) dut (
        .clk(clk), .rst_n(rst_n), .den_in(den_in), .dwe_in(dwe_in),
        .daddr_in(daddr_in), .di_in(di_in), .do_out(do_out), .drdy_out(drdy_out),
        .eoc_out(eoc_out), .channel_out(channel_out),
        .ain0_in(ain0), .ain1_in(ain1), .ain2_in(ain2), .ain3_in(ain3),
        .drp_err_out(drp_err_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          e_cnt = -1;     // index of most recent active clock edge since reset release
    int          act_n = 0;      // number of unpaused clocks since reset release
    int          m_due, m_resp_edge;
    logic [11:0] m_samp [4];
    logic [15:0] m_cfg0, m_cfg1, m_wd;
    logic [6:0]  m_addr;
    logic        m_we, m_pend;
    logic        m_started = 1'b0;
    logic        exp_eoc, exp_drdy, exp_err;
    logic [6:0]  exp_chan;
    logic [15:0] exp_do;
    logic        pause_v, illegal_v;
    int          k_v;

    function automatic logic [6:0] slot_addr(input int k);
        logic [6:0] a;
        case (k)
            0: a = 7'h16;
            1: a = 7'h17;
            2: a = 7'h1E;
            default: a = 7'h1F;
        endcase
        return a;
    endfunction

    function automatic logic [11:0] ain_of(input int k);
        logic [11:0] v;
        case (k)
            0: v = ain0;
            1: v = ain1;
            2: v = ain2;
            default: v = ain3;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [6:0] a);
        logic [15:0] v;
        case (a)
            7'h16: v = {m_samp[0], 4'h0};
            7'h17: v = {m_samp[1], 4'h0};
            7'h1E: v = {m_samp[2], 4'h0};
            7'h1F: v = {m_samp[3], 4'h0};
            7'h40: v = m_cfg0;
            7'h41: v = m_cfg1;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!rst_n) begin
            e_cnt = -1; act_n = 0; m_pend = 1'b0; m_resp_edge = -10; m_due = 0;
            for (int k = 0; k < 4; k++) m_samp[k] = 12'h000;
            m_cfg0 = 16'h0000; m_cfg1 = 16'h0000;
            exp_eoc = 1'b0; exp_drdy = 1'b0; exp_err = 1'b0;
            exp_chan = 7'h00; exp_do = 16'h0000;
        end else begin
            e_cnt++;
            pause_v   = m_cfg1[0];
            exp_drdy  = 1'b0;
            exp_eoc   = 1'b0;
            illegal_v = m_pend || (e_cnt == m_resp_edge + 1);
            // transaction completion (sees register contents before this clock)
            if (m_pend && e_cnt == m_due) begin
                if (m_we) begin
                    exp_do = 16'h0000;
                    if (m_addr == 7'h40) m_cfg0 = m_wd;
                    else if (m_addr == 7'h41) m_cfg1 = m_wd;
                end else begin
                    exp_do = m_read(m_addr);
                end
                exp_drdy = 1'b1; m_pend = 1'b0; m_resp_edge = e_cnt;
            end
            if (den_in) begin
                if (illegal_v) exp_err = 1'b1;
                else begin
                    m_pend = 1'b1; m_due = e_cnt + RLAT - 1;
                    m_addr = daddr_in; m_we = dwe_in; m_wd = di_in;
                end
            end
            // conversions: one every CONV unpaused clocks, channels in rotation
            if (!pause_v) begin
                if (act_n % CONV == CONV - 1) begin
                    k_v = (act_n / CONV) % 4;
                    m_samp[k_v] = ain_of(k_v);
                    exp_eoc = 1'b1;
                    exp_chan = slot_addr(k_v);
                end
                act_n++;
            end
        end
    end

    // Cycle-by-cycle output comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check_eq("eoc_out",     32'(eoc_out),     32'(exp_eoc));
            check_eq("channel_out", 32'(channel_out), 32'(exp_chan));
            check_eq("drdy_out",    32'(drdy_out),    32'(exp_drdy));
            check_eq("do_out",      32'(do_out),      32'(exp_do));
            check_eq("drp_err_out", 32'(drp_err_out), 32'(exp_err));
        end
    end

    // eoc log for timing/order checks
    int         eoc_t[$];
    logic [6:0] eoc_c[$];
    always @(negedge clk) begin
        if (eoc_out === 1'b1) begin
            eoc_t.push_back(e_cnt);
            eoc_c.push_back(channel_out);
        end
    end

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; den_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        eoc_t.delete(); eoc_c.delete();
    endtask

    // One DRP transaction; returns read data and den-to-drdy latency.
    task automatic drp_txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        int t0;
        bit got;
        @(negedge clk);
        den_in = 1'b1; dwe_in = we; daddr_in = a; di_in = d; t0 = e_cnt;
        @(negedge clk);
        den_in = 1'b0; dwe_in = 1'b0;
        got = 1'b0; lat = -1; rd = 16'h0000;
        for (int i = 0; i < 20 && !got; i++) begin
            if (drdy_out === 1'b1) begin
                got = 1'b1; lat = e_cnt - t0; rd = do_out;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check_eq("drdy_wait_expired", 32'd0, 32'd1);
    endtask

    logic [15:0] rd;
    int lat, n, base;
    int n_eoc_loop, n_drdy_loop;
    logic [6:0] a_r;
    logic we_r;
    logic [15:0] d_r;

    initial begin
        // 1. reset release and conversion sequence
        ain0 = 12'hABC; ain1 = 12'h123; ain2 = 12'h7FF; ain3 = 12'hFFF;
        do_reset();
        check_eq("reset_do", 32'(do_out), 32'h0);
        for (int i = 0; i < 200 && eoc_t.size() < 5; i++) @(negedge clk);
        check_eq("eoc_count5", 32'(eoc_t.size()), 32'd5);
        if (eoc_t.size() >= 5) begin
            check_eq("first_eoc_cycle", 32'(eoc_t[0]), 32'd25);
            for (int i = 1; i < 5; i++) check_eq("eoc_period", 32'(eoc_t[i] - eoc_t[i-1]), 32'd26);
            check_eq("chan0", 32'(eoc_c[0]), 32'h16);
            check_eq("chan1", 32'(eoc_c[1]), 32'h17);
            check_eq("chan2", 32'(eoc_c[2]), 32'h1E);
            check_eq("chan3", 32'(eoc_c[3]), 32'h1F);
            check_eq("chan4", 32'(eoc_c[4]), 32'h16);
        end

        // 2. read sample 0x1E; value held afterwards
        drp_txn(7'h1E, 1'b0, 16'h0000, rd, lat);
        check_eq("rd1E_lat", 32'(lat), 32'd4);
        check_eq("rd1E_data", 32'(rd), 32'h7FF0);
        repeat (5) @(negedge clk);
        check_eq("rd1E_hold", 32'(do_out), 32'h7FF0);

        // 3. pause via CFG1
        drp_txn(7'h41, 1'b1, 16'h0001, rd, lat);
        check_eq("wrpause_lat", 32'(lat), 32'd4);
        check_eq("wrpause_do", 32'(rd), 32'h0000);
        @(negedge clk);
        base = eoc_t.size();
        repeat (200) @(negedge clk);
        check_eq("paused_no_eoc", 32'(eoc_t.size() - base), 32'd0);
        drp_txn(7'h41, 1'b0, 16'h0000, rd, lat);
        check_eq("rdcfg1", 32'(rd), 32'h0001);
        drp_txn(7'h41, 1'b1, 16'h0000, rd, lat);
        for (int i = 0; i < 40 && eoc_t.size() == base; i++) @(negedge clk);
        check_eq("eoc_resumed", 32'(eoc_t.size() > base), 32'd1);

        // 4. unmapped read, discarded write to a sample register
        drp_txn(7'h05, 1'b0, 16'h0000, rd, lat);
        check_eq("rd05_lat", 32'(lat), 32'd4);
        check_eq("rd05_data", 32'(rd), 32'h0000);
        drp_txn(7'h16, 1'b1, 16'h5555, rd, lat);
        check_eq("wr16_lat", 32'(lat), 32'd4);
        drp_txn(7'h16, 1'b0, 16'h0000, rd, lat);
        check_eq("rd16_data", 32'(rd), 32'hABC0);

        // 5. den while busy: one drdy, sticky error
        @(negedge clk); den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h17;
        @(negedge clk); den_in = 1'b0;
        @(negedge clk); den_in = 1'b1;
        @(negedge clk); den_in = 1'b0;
        n = 0;
        repeat (8) begin @(negedge clk); if (drdy_out === 1'b1) n++; end
        check_eq("busy_den_one_drdy", 32'(n), 32'd1);
        check_eq("err_set", 32'(drp_err_out), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("err_sticky", 32'(drp_err_out), 32'd1);

        // 6. reset during a transaction
        @(negedge clk); den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h16;
        @(negedge clk); den_in = 1'b0; rst_n = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); if (drdy_out === 1'b1) n++; end
        rst_n = 1'b1; eoc_t.delete(); eoc_c.delete();
        repeat (10) begin @(negedge clk); if (drdy_out === 1'b1) n++; end
        check_eq("rst_no_drdy", 32'(n), 32'd0);
        check_eq("rst_do_zero", 32'(do_out), 32'h0);
        check_eq("rst_err_clear", 32'(drp_err_out), 32'd0);
        for (int i = 0; i < 40 && eoc_t.size() == 0; i++) @(negedge clk);
        if (eoc_t.size() > 0) check_eq("rst_first_eoc", 32'(eoc_t[0]), 32'd25);
        else check_eq("rst_first_eoc_seen", 32'd0, 32'd1);

        // 7. initiator loop: den driven from eoc
        n_eoc_loop = 0; n_drdy_loop = 0;
        repeat (CONV * 6) begin
            @(negedge clk);
            if (drdy_out === 1'b1) n_drdy_loop++;
            den_in = eoc_out; dwe_in = 1'b0; daddr_in = channel_out;
            if (eoc_out === 1'b1) n_eoc_loop++;
        end
        repeat (8) begin
            @(negedge clk);
            if (drdy_out === 1'b1) n_drdy_loop++;
            den_in = 1'b0;
        end
        check_eq("loop_saw_eoc", 32'(n_eoc_loop > 3), 32'd1);
        check_eq("loop_drdy_per_eoc", 32'(n_drdy_loop), 32'(n_eoc_loop));
        check_eq("loop_no_err", 32'(drp_err_out), 32'd0);

        // 8. randomized traffic with changing analog inputs
        repeat (80) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                ain0 = 12'($urandom); ain1 = 12'($urandom);
                ain2 = 12'($urandom); ain3 = 12'($urandom);
            end
            case ($urandom_range(0, 7))
                0: a_r = 7'h16;
                1: a_r = 7'h17;
                2: a_r = 7'h1E;
                3: a_r = 7'h1F;
                4: a_r = 7'h40;
                5: a_r = 7'h41;
                default: a_r = 7'($urandom);
            endcase
            we_r = 1'($urandom);
            d_r  = 16'($urandom);
            if (a_r == 7'h41) d_r[0] = ($urandom_range(0, 3) == 0);
            drp_txn(a_r, we_r, d_r, rd, lat);
            check_eq("rand_lat", 32'(lat), 32'd4);
        end
        drp_txn(7'h41, 1'b1, 16'h0000, rd, lat);
        repeat (60) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
